// File: rtl/booth_mul_if.sv
// Handshake and operand/product bundle between the control unit and the
// radix-4 Booth multiplier.
interface booth_mul_if;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product_hi, product_lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product_hi, product_lo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential signed 32x32->64 multiplier, radix-4 Booth, one bit-pair per clock.
// The product is registered and only changes when an operation completes.
module booth_mul_seq (
    input  logic         clk,
    input  logic         clr,
    booth_mul_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         count_reg, count_next;
    logic signed [33:0] acc_reg, acc_next;
    logic signed [33:0] mcand_reg, mcand_next;
    logic [31:0]        q_reg, q_next;
    logic               q_m1_reg, q_m1_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;

    logic signed [33:0] mcand_x2;
    logic signed [33:0] addend;
    logic signed [33:0] sum;
    logic               load;

    assign mcand_x2 = {mcand_reg[32:0], 1'b0};

    always_comb begin
        addend = '0;
        case ({q_reg[1:0], q_m1_reg})
            3'b001, 3'b010: addend = mcand_reg;
            3'b011:         addend = mcand_x2;
            3'b100:         addend = -mcand_x2;
            3'b101, 3'b110: addend = -mcand_reg;
            default:        addend = '0;
        endcase
        sum = acc_reg + addend;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            count_reg <= '0;
            acc_reg   <= '0;
            mcand_reg <= '0;
            q_reg     <= '0;
            q_m1_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            acc_reg   <= acc_next;
            mcand_reg <= mcand_next;
            q_reg     <= q_next;
            q_m1_reg  <= q_m1_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        acc_next   = acc_reg;
        mcand_next = mcand_reg;
        q_next     = q_reg;
        q_m1_next  = q_m1_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        load       = 1'b0;

        case (state_reg)
            IDLE: load = bus.start;
            RUN: begin
                // Add, then shift {acc, q, q_m1} right by two with sign fill.
                acc_next   = {{2{sum[33]}}, sum[33:2]};
                q_next     = {sum[1:0], q_reg[31:2]};
                q_m1_next  = q_reg[1];
                count_next = count_reg + 4'd1;
                if (count_reg == 4'd15) begin
                    state_next = DONE;
                    hi_next    = acc_next[31:0];
                    lo_next    = q_next;
                end
            end
            // A start present on the edge leaving DONE is taken there, so a
            // held start gives one multiply every 17 cycles.
            DONE: begin
                state_next = IDLE;
                load       = bus.start;
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            acc_next   = '0;
            q_next     = bus.multiplier;
            q_m1_next  = 1'b0;
            mcand_next = {{2{bus.multiplicand[31]}}, bus.multiplicand};
            count_next = '0;
            state_next = RUN;
        end
    end

    assign bus.busy       = (state_reg == RUN);
    assign bus.done       = (state_reg == DONE);
    assign bus.product_hi = hi_reg;
    assign bus.product_lo = lo_reg;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Table-driven bench for booth_mul_seq with a product scoreboard queue and
// hand-written sequences for held start, mid-run clear and clear-vs-start.
module tb_booth_mul_seq;
    logic clk = 1'b0;
    logic clr;

    booth_mul_if bus_if ();

    booth_mul_seq dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t        vecs [12];
    logic [63:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_compare(input string name);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, {bus_if.product_hi, bus_if.product_lo}, e);
            $display("mul done: product=0x%08h_%08h expected=0x%016h",
                     bus_if.product_hi, bus_if.product_lo, e);
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p,
                           input string name);
        int cyc;
        int busy_cnt;
        bit got;
        exp_q.push_back(p);
        bus_if.start        = 1'b1;
        bus_if.multiplicand = a;
        bus_if.multiplier   = b;
        tick();
        bus_if.start        = 1'b0;
        bus_if.multiplicand = $urandom;
        bus_if.multiplier   = $urandom;
        busy_cnt = bus_if.busy ? 1 : 0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 40 && !got) begin
            tick();
            cyc++;
            bus_if.multiplicand = $urandom;
            bus_if.multiplier   = $urandom;
            if (bus_if.done) got = 1'b1;
            else if (bus_if.busy) busy_cnt++;
        end
        if (!got) begin
            check({name, "_timeout"}, 64'(cyc), 64'd16);
            void'(exp_q.pop_front());
            return;
        end
        check({name, "_latency"}, 64'(cyc), 64'd16);
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd16);
        pop_compare(name);
        tick();
        check({name, "_done_pulse"}, 64'(bus_if.done), 64'd0);
        check({name, "_hold"}, {bus_if.product_hi, bus_if.product_lo}, p);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ha, hb, hc, hd;
        int          cyc;
        int          got;
        bit          seen;

        vecs[0]  = '{32'h0000_0022, 32'h0000_0024, 64'h0000_0000_0000_04C8};
        vecs[1]  = '{32'hFFFF_FFFB, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[3]  = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4]  = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[5]  = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[6]  = '{32'h0000_0001, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000};
        vecs[7]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        for (int i = 8; i < 12; i++) begin
            vecs[i].a = $urandom;
            vecs[i].b = $urandom;
            vecs[i].p = model(vecs[i].a, vecs[i].b);
        end

        clr                 = 1'b1;
        bus_if.start        = 1'b0;
        bus_if.multiplicand = '0;
        bus_if.multiplier   = '0;
        tick();
        tick();
        check("reset_busy", 64'(bus_if.busy), 64'd0);
        check("reset_done", 64'(bus_if.done), 64'd0);
        check("reset_product", {bus_if.product_hi, bus_if.product_lo}, 64'd0);
        clr = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            $display("vector %0d: 0x%08h x 0x%08h", i, vecs[i].a, vecs[i].b);
            run_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Held start: operands churn mid-run, second op takes what is on E17.
        ha = 32'hFFFF_0001; hb = 32'h0001_2345;
        hc = 32'h8000_0001; hd = 32'h7FFF_FFFE;
        exp_q.push_back(model(ha, hb));
        bus_if.start        = 1'b1;
        bus_if.multiplicand = ha;
        bus_if.multiplier   = hb;
        tick();
        check("held_busy_e0", 64'(bus_if.busy), 64'd1);
        cyc = 0;
        got = 0;
        while (cyc < 45 && got < 2) begin
            tick();
            cyc++;
            if (cyc < 10) begin
                bus_if.multiplicand = $urandom;
                bus_if.multiplier   = $urandom;
            end else if (cyc == 10) begin
                bus_if.multiplicand = hc;
                bus_if.multiplier   = hd;
                exp_q.push_back(model(hc, hd));
            end
            if (bus_if.done) begin
                got++;
                if (got == 1) check("held_first_latency", 64'(cyc), 64'd16);
                else          check("held_second_latency", 64'(cyc), 64'd33);
                pop_compare(got == 1 ? "held_first" : "held_second");
            end
            if (cyc == 17) begin
                bus_if.start = 1'b0;
                check("held_accept_e17", 64'(bus_if.busy), 64'd1);
            end
        end
        check("held_done_count", 64'(got), 64'd2);
        exp_q.delete();
        bus_if.start = 1'b0;
        tick();

        // Abort with clr at step 8, then a clean multiply.
        run_mul(32'h0000_0022, 32'h0000_0024, 64'h4C8, "pre_abort");
        bus_if.start        = 1'b1;
        bus_if.multiplicand = 32'h0000_1234;
        bus_if.multiplier   = 32'h0000_0010;
        tick();
        bus_if.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_busy", 64'(bus_if.busy), 64'd0);
        check("abort_done", 64'(bus_if.done), 64'd0);
        check("abort_product", {bus_if.product_hi, bus_if.product_lo}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus_if.done) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        $display("abort sequence: 0x1234 x 0x10 cleared at step 8");
        run_mul(32'h0000_0002, 32'h0000_0003, 64'h6, "post_abort");

        // clr and start together in IDLE.
        bus_if.start        = 1'b1;
        bus_if.multiplicand = 32'h0000_0005;
        bus_if.multiplier   = 32'h0000_0007;
        clr                 = 1'b1;
        tick();
        bus_if.start = 1'b0;
        clr          = 1'b0;
        check("clr_start_busy", 64'(bus_if.busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_if.done || bus_if.busy) seen = 1'b1;
        end
        check("clr_start_idle", 64'(seen), 64'd0);
        check("clr_start_product", {bus_if.product_hi, bus_if.product_lo}, 64'd0);
        $display("clr+start sequence: stayed idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
